// File: rtl/riscv_pkg.sv
// Shared fetch-stage constants and the {pc, instr} entry layout.
package riscv_pkg;

    localparam int XLEN             = 32;
    localparam int FETCH_FIFO_DEPTH = 2;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int FETCH_PC_W    = XLEN;
    localparam int FETCH_INSTR_W = XLEN;
    localparam int FETCH_ENTRY_W = FETCH_PC_W + FETCH_INSTR_W;

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response and decode handoff signals of the fetch stage.
interface instr_fetch_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    logic            instr_valid;
    logic [XLEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    // master: the fetch stage; slave: the memory/decode environment around it
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries; head is visible combinationally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one imem read at a time at pc_in, buffers {pc, instr} for decode,
// and drops stale words after a PC redirect.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    input  logic            halt,
    input  logic            flush,
    instr_fetch_if.master   bus,
    output logic            freeze_pc,
    output logic            fetch_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             outstanding;
    logic             discard;
    logic [XLEN-1:0]  req_pc;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             slot_free;
    logic             eligible;
    logic             fire;
    logic             rsp_accept;
    logic             push;
    logic             pop;

    // Reserve a FIFO slot for the in-flight word so a response can never overflow.
    assign slot_free  = (fifo_count + CNT_W'(outstanding)) < CNT_W'(FIFO_DEPTH);
    assign eligible   = rst_n && !halt && !flush && !fetch_fault && !outstanding && slot_free;

    assign bus.imem_req_valid = eligible && word_aligned(pc_in);
    assign bus.imem_req_addr  = pc_in;
    assign fire               = bus.imem_req_valid && bus.imem_req_ready;
    assign freeze_pc          = !fire;

    // Responses with nothing outstanding (e.g. after a reset) are ignored.
    assign rsp_accept = bus.imem_rsp_valid && outstanding;
    assign push       = rsp_accept && !discard && !flush;
    assign pop        = bus.instr_valid && bus.instr_ready;
    assign push_entry = '{pc: req_pc, instr: bus.imem_rsp_data};

    assign bus.instr_valid = !fifo_empty;
    assign bus.instr_pc    = head_entry.pc;
    assign bus.instr_data  = head_entry.instr;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FETCH_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_entry),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
            discard     <= 1'b0;
            req_pc      <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (fire) begin
                outstanding <= 1'b1;
                req_pc      <= pc_in;
            end else if (rsp_accept) begin
                outstanding <= 1'b0;
            end

            // A redirect with a word still in flight marks that word as stale.
            if (flush && outstanding && !bus.imem_rsp_valid) begin
                discard <= 1'b1;
            end else if (rsp_accept) begin
                discard <= 1'b0;
            end

            if (flush) begin
                fetch_fault <= 1'b0;
            end else if (eligible && !word_aligned(pc_in)) begin
                fetch_fault <= 1'b1;
            end
        end
    end

endmodule
